// File: rtl/prog_lut.sv
// Run-time writable branch-target/immediate table with registered reads,
// per-field masked writes, write-first bypass and a sequential clear sweep.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | table accepts writes; reads return stored or bypassed data
// SWEEP | one entry zeroed per edge from ptr 0 up to DEPTH-1; writes drop
module prog_lut #(
    parameter int ADDR_W = 3,
    parameter int TGT_W  = 10,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [TGT_W-1:0]  target,
    output logic [IMM_W-1:0]  immediate,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_sel,
    input  logic [TGT_W-1:0]  wr_target,
    input  logic [IMM_W-1:0]  wr_imm,
    input  logic              clr,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              done_nxt;
    logic              drop_nxt;
    logic              zero_en;
    logic              wr_ok;

    logic [TGT_W-1:0]  tgt_mem [DEPTH];
    logic [IMM_W-1:0]  imm_mem [DEPTH];
    logic [TGT_W-1:0]  rd_tgt;
    logic [IMM_W-1:0]  rd_imm;

    // A restart edge only rewinds the pointer; zeroing resumes next edge.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        done_nxt  = 1'b0;
        drop_nxt  = 1'b0;
        zero_en   = 1'b0;
        wr_ok     = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                    drop_nxt  = wr_en;
                end else begin
                    wr_ok = wr_en;
                end
            end
            SWEEP: begin
                drop_nxt = wr_en;
                if (clr) begin
                    ptr_nxt = '0;
                end else begin
                    zero_en = 1'b1;
                    if (ptr == LAST_IDX) begin
                        state_nxt = IDLE;
                        ptr_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        ptr_nxt = ptr + ADDR_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read path sees the table as it will be after this edge.
    always_comb begin
        rd_tgt = tgt_mem[rd_addr];
        rd_imm = imm_mem[rd_addr];
        if (zero_en && (ptr == rd_addr)) begin
            rd_tgt = '0;
            rd_imm = '0;
        end
        if (wr_ok && (wr_addr == rd_addr)) begin
            if (wr_sel[0]) rd_tgt = wr_target;
            if (wr_sel[1]) rd_imm = wr_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            clr_done <= done_nxt;
            wr_drop  <= drop_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tgt_mem[i] <= '0;
                imm_mem[i] <= '0;
            end
        end else begin
            if (zero_en) begin
                tgt_mem[ptr] <= '0;
                imm_mem[ptr] <= '0;
            end
            if (wr_ok && wr_sel[0]) tgt_mem[wr_addr] <= wr_target;
            if (wr_ok && wr_sel[1]) imm_mem[wr_addr] <= wr_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target    <= '0;
            immediate <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                target    <= rd_tgt;
                immediate <= rd_imm;
            end
        end
    end

    assign busy = (state == SWEEP);

endmodule

// File: tb/tb_prog_lut.sv
// Randomized and directed checks of prog_lut against an array-based table model.
module tb_prog_lut;

    logic clk;
    logic rst_n;

    logic       a_rd_en, a_wr_en, a_clr;
    logic [2:0] a_rd_addr, a_wr_addr;
    logic [1:0] a_wr_sel;
    logic [9:0] a_wr_target, a_target;
    logic [7:0] a_wr_imm, a_immediate;
    logic       a_rd_valid, a_busy, a_clr_done, a_wr_drop;

    logic        b_rd_en, b_wr_en, b_clr;
    logic [3:0]  b_rd_addr, b_wr_addr;
    logic [1:0]  b_wr_sel;
    logic [11:0] b_wr_target, b_target;
    logic [8:0]  b_wr_imm, b_immediate;
    logic        b_rd_valid, b_busy, b_clr_done, b_wr_drop;

    int n_chk = 0;
    int n_bad = 0;

    logic [9:0] m_tgt [8];
    logic [7:0] m_imm [8];
    int         m_pos;
    logic       m_busy;
    logic       e_rv, e_done, e_drop;
    logic [9:0] e_t;
    logic [7:0] e_i;

    prog_lut #(.ADDR_W(3), .TGT_W(10), .IMM_W(8)) u_a (
        .clk(clk), .rst_n(rst_n),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .target(a_target),
        .immediate(a_immediate), .rd_valid(a_rd_valid),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_sel(a_wr_sel),
        .wr_target(a_wr_target), .wr_imm(a_wr_imm),
        .clr(a_clr), .busy(a_busy), .clr_done(a_clr_done), .wr_drop(a_wr_drop)
    );

    prog_lut #(.ADDR_W(4), .TGT_W(12), .IMM_W(9)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .target(b_target),
        .immediate(b_immediate), .rd_valid(b_rd_valid),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_sel(b_wr_sel),
        .wr_target(b_wr_target), .wr_imm(b_wr_imm),
        .clr(b_clr), .busy(b_busy), .clr_done(b_clr_done), .wr_drop(b_wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_tgt[i] = '0;
            m_imm[i] = '0;
        end
        m_pos  = 0;
        m_busy = 1'b0;
        e_rv = 1'b0; e_done = 1'b0; e_drop = 1'b0;
        e_t  = '0;   e_i    = '0;
    endtask

    // Apply this edge's effect on the table first, then read: this gives
    // write-first and sweep bypass for free.
    task automatic model_edge();
        int ra = int'(a_rd_addr);
        int wa = int'(a_wr_addr);
        e_rv   = a_rd_en;
        e_done = 1'b0;
        e_drop = 1'b0;
        if (a_clr) begin
            e_drop = a_wr_en;
            m_busy = 1'b1;
            m_pos  = 0;
        end else if (m_busy) begin
            e_drop       = a_wr_en;
            m_tgt[m_pos] = '0;
            m_imm[m_pos] = '0;
            if (m_pos == 7) begin
                m_busy = 1'b0;
                e_done = 1'b1;
            end else begin
                m_pos++;
            end
        end else if (a_wr_en) begin
            if (a_wr_sel[0]) m_tgt[wa] = a_wr_target;
            if (a_wr_sel[1]) m_imm[wa] = a_wr_imm;
        end
        if (a_rd_en) begin
            e_t = m_tgt[ra];
            e_i = m_imm[ra];
        end
    endtask

    task automatic cyc_a();
        model_edge();
        @(posedge clk);
        #1;
        chk("a_rd_valid", 32'(a_rd_valid), 32'(e_rv));
        chk("a_target", 32'(a_target), 32'(e_t));
        chk("a_immediate", 32'(a_immediate), 32'(e_i));
        chk("a_busy", 32'(a_busy), 32'(m_busy));
        chk("a_clr_done", 32'(a_clr_done), 32'(e_done));
        chk("a_wr_drop", 32'(a_wr_drop), 32'(e_drop));
    endtask

    task automatic idle_a();
        a_rd_en = 1'b0; a_wr_en = 1'b0; a_clr = 1'b0;
        a_rd_addr = '0; a_wr_addr = '0; a_wr_sel = '0;
        a_wr_target = '0; a_wr_imm = '0;
    endtask

    task automatic write_a(input int addr, input int sel, input int t, input int i);
        a_wr_en = 1'b1; a_wr_addr = 3'(addr); a_wr_sel = 2'(sel);
        a_wr_target = 10'(t); a_wr_imm = 8'(i);
    endtask

    task automatic cyc_b();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_outputs_zero(input string tag);
        chk({tag, "_rv"}, 32'(a_rd_valid), 32'd0);
        chk({tag, "_tgt"}, 32'(a_target), 32'd0);
        chk({tag, "_imm"}, 32'(a_immediate), 32'd0);
        chk({tag, "_busy"}, 32'(a_busy), 32'd0);
        chk({tag, "_done"}, 32'(a_clr_done), 32'd0);
        chk({tag, "_drop"}, 32'(a_wr_drop), 32'd0);
    endtask

    initial begin
        int n;
        int done_cnt;
        logic [11:0] bt [16];
        logic [8:0]  bi [16];

        rst_n = 1'b0;
        idle_a();
        b_rd_en = 1'b0; b_wr_en = 1'b0; b_clr = 1'b0;
        b_rd_addr = '0; b_wr_addr = '0; b_wr_sel = '0;
        b_wr_target = '0; b_wr_imm = '0;
        model_reset();

        #12;
        check_all_outputs_zero("reset");
        chk("b_reset_busy", 32'(b_busy), 32'd0);
        chk("b_reset_rv", 32'(b_rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // defaults after reset
        for (int i = 0; i < 8; i++) begin
            a_rd_en = 1'b1; a_rd_addr = 3'(i);
            cyc_a();
            chk("default_tgt", 32'(a_target), 32'd0);
        end
        idle_a();
        cyc_a();

        // full then masked write of entry 2
        write_a(2, 3, 'h1F0, 30);
        cyc_a();
        idle_a(); a_rd_en = 1'b1; a_rd_addr = 3'd2;
        cyc_a();
        chk("e2_tgt", 32'(a_target), 32'h1F0);
        chk("e2_imm", 32'(a_immediate), 32'd30);
        idle_a(); write_a(2, 1, 'h2F0, 99);
        cyc_a();
        idle_a(); a_rd_en = 1'b1; a_rd_addr = 3'd2;
        cyc_a();
        chk("e2m_tgt", 32'(a_target), 32'h2F0);
        chk("e2m_imm", 32'(a_immediate), 32'd30);

        // same-edge write/read
        idle_a(); write_a(5, 3, 'h3F0, 128); a_rd_en = 1'b1; a_rd_addr = 3'd5;
        cyc_a();
        chk("wf_tgt", 32'(a_target), 32'h3F0);
        chk("wf_imm", 32'(a_immediate), 32'd128);
        idle_a(); write_a(0, 0, 'h3FF, 255);
        cyc_a();

        // fill, clear, restart clear three cycles later
        for (int i = 0; i < 8; i++) begin
            idle_a(); write_a(i, 3, (i + 1) * 'h41, i + 'h11);
            cyc_a();
        end
        idle_a(); a_clr = 1'b1;
        cyc_a();
        a_clr = 1'b0;
        cyc_a();
        cyc_a();
        a_clr = 1'b1;
        cyc_a();
        a_clr = 1'b0;
        n = 1;
        done_cnt = 0;
        while (a_busy && n < 40) begin
            idle_a();
            a_rd_en = 1'b1; a_rd_addr = 3'($urandom_range(0, 7));
            if (n == 3) write_a(0, 3, 'h155, 'h5A);
            cyc_a();
            n++;
            if (a_clr_done) done_cnt++;
        end
        chk("sweep_cycles", 32'(n), 32'd9);
        chk("sweep_done_pulses", 32'(done_cnt), 32'd1);
        idle_a();
        for (int i = 0; i < 8; i++) begin
            a_rd_en = 1'b1; a_rd_addr = 3'(i);
            cyc_a();
            chk("cleared_tgt", 32'(a_target), 32'd0);
            chk("cleared_imm", 32'(a_immediate), 32'd0);
        end

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            a_rd_en     = 1'($urandom);
            a_rd_addr   = 3'($urandom);
            a_wr_en     = 1'($urandom);
            a_wr_addr   = 3'($urandom);
            a_wr_sel    = 2'($urandom);
            a_wr_target = 10'($urandom);
            a_wr_imm    = 8'($urandom);
            a_clr       = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) a_rd_addr = a_wr_addr;
            cyc_a();
        end
        idle_a();
        n = 0;
        while (m_busy && n < 20) begin
            cyc_a();
            n++;
        end

        // reset during a sweep with a read and a dropped write in flight
        write_a(7, 3, 'h155, 'h5A);
        cyc_a();
        idle_a(); a_clr = 1'b1; a_rd_en = 1'b1; a_rd_addr = 3'd7;
        cyc_a();
        a_clr = 1'b0; write_a(3, 3, 'h3FF, 'hFF);
        cyc_a();
        chk("pre_rst_tgt", 32'(a_target), 32'h155);
        chk("pre_rst_drop", 32'(a_wr_drop), 32'd1);
        idle_a();
        rst_n = 1'b0;
        #2;
        check_all_outputs_zero("async_rst");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            a_rd_en = 1'b1; a_rd_addr = 3'(7 - i);
            cyc_a();
        end
        idle_a();
        cyc_a();

        // wider instance: fill all 16 entries and read back
        for (int i = 0; i < 16; i++) begin
            bt[i] = 12'((i * 'h111 + 'h7A3) & 'hFFF);
            bi[i] = 9'((i * 37 + 1) & 'h1FF);
            b_wr_en = 1'b1; b_wr_addr = 4'(i); b_wr_sel = 2'b11;
            b_wr_target = bt[i]; b_wr_imm = bi[i];
            cyc_b();
        end
        b_wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_rd_en = 1'b1; b_rd_addr = 4'(15 - i);
            cyc_b();
            chk("b_rv", 32'(b_rd_valid), 32'd1);
            chk("b_tgt", 32'(b_target), 32'(bt[15 - i]));
            chk("b_imm", 32'(b_immediate), 32'(bi[15 - i]));
        end
        b_rd_en = 1'b0; b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_sel = 2'b10;
        b_wr_target = 12'hFFF; b_wr_imm = 9'h0AA;
        cyc_b();
        b_wr_en = 1'b0; b_rd_en = 1'b1; b_rd_addr = 4'd15;
        cyc_b();
        chk("b15_tgt", 32'(b_target), 32'(bt[15]));
        chk("b15_imm", 32'(b_immediate), 32'h0AA);
        b_wr_en = 1'b1; b_wr_addr = 4'd9; b_wr_sel = 2'b01;
        b_wr_target = 12'h9C3; b_wr_imm = 9'h1FF; b_rd_addr = 4'd9;
        cyc_b();
        chk("b9_wf_tgt", 32'(b_target), 32'h9C3);
        chk("b9_wf_imm", 32'(b_immediate), 32'(bi[9]));
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        cyc_b();
        chk("b_rv_low", 32'(b_rd_valid), 32'd0);
        chk("b_hold_tgt", 32'(b_target), 32'h9C3);
        chk("b_busy_idle", 32'(b_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_lut.md
# prog_lut

Programmable branch-target/immediate lookup table for the 9-bit processor. It replaces fixed-constant pointer tables with a run-time-writable table, parametrised in address, target and immediate width. Storage is flop-based with registered reads, masked writes, write-first bypass, and a sequential clear sweep that models a memory-backed table. It sits between the decoder (read side) and the loader/debug path (write side).

## Interface
- ADDR_W, 3, table index width; DEPTH = 2**ADDR_W entries (localparam); ADDR_W >= 1
- TGT_W, 10, branch-target field width
- IMM_W, 8, immediate field width
- Clk  in  1  single clock; all state updates on rising edge
- Reset_n  in  1  reset, asynchronous, active-low
- RdEn  in  1  read request
- RdAddr  in  ADDR_W  read index
- Target  out  TGT_W  registered target field of last accepted read
- Immediate  out  IMM_W  registered immediate field of last accepted read
- RdValid  out  1  high for the cycle after an accepted read
- WrEn  in  1  write request
- WrAddr  in  ADDR_W  write index
- WrSel  in  2  bit0 updates target field, bit1 updates immediate field
- WrTarget  in  TGT_W  target write data
- WrImm  in  IMM_W  immediate write data
- Clr  in  1  start clear sweep
- Busy  out  1  sweep in progress
- ClrDone  out  1  one-cycle pulse at sweep completion
- WrDrop  out  1  one-cycle pulse: a write was discarded

## Operation
- Storage: DEPTH entries of {target, immediate}.
- Reset_n low: all entries, Target, Immediate, RdValid, Busy, ClrDone, WrDrop and sweep pointer go to 0; FSM goes to IDLE. This takes effect immediately, mid-sweep included.
- Read: RdEn sampled high at edge N loads Target/Immediate from entry RdAddr and sets RdValid=1 after N. When RdEn is low, RdValid=0 and Target/Immediate hold.
- Write (IDLE only): WrEn at edge N updates only the fields selected by WrSel; WrSel=00 is a legal no-op (no WrDrop).
- Read/write same address, same edge: the read returns the post-write value (write-first), per field as masked by WrSel.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP on Clr; pointer set to 0.
  - SWEEP: zero entry[pointer] each edge and increment the pointer.
  - After the entry DEPTH-1 write: SWEEP -> IDLE and ClrDone=1 for one cycle.
  - Clr in SWEEP restarts: pointer goes to 0, state stays SWEEP, no ClrDone.
- Busy = (state == SWEEP).
- WrEn during SWEEP, or WrEn coincident with Clr in IDLE: the write is discarded and WrDrop=1 the following cycle. Clr has priority.
- Reads stay legal during SWEEP. A read of the entry being zeroed at the same edge returns 0 (bypass). Other entries return their current content.
- Pointer is ADDR_W wide and never wraps past DEPTH-1 inside a sweep.

## Timing
- Read latency: 1 cycle (RdEn at edge N -> data and RdValid valid after N). Back-to-back reads every cycle are supported.
- Write latency: visible to a read accepted at the same edge (bypass), and stored after that edge.
- Sweep: Clr at edge N -> Busy=1 after N. Entries 0..DEPTH-1 are zeroed at edges N+1..N+DEPTH. Busy=0 and ClrDone=1 after N+DEPTH. Total DEPTH+1 cycles from Clr to idle.
- WrDrop and ClrDone are exactly one cycle wide, registered, with no combinational paths from inputs to outputs.

## Test plan
- Reset, then read all 8 entries (defaults) -> Target=0, Immediate=0, with RdValid one cycle after each RdEn.
- Write entry 2 with WrTarget=0x1F0, WrImm=30, WrSel=11, then read 2 -> 0x1F0/30. Write entry 2 with WrSel=01, WrTarget=0x2F0, WrImm=99, then read -> 0x2F0/30.
- Same-edge write entry 5 (0x3F0/128, WrSel=11) and read 5 -> Target=0x3F0, Immediate=128 next cycle.
- Fill all entries with nonzero data, pulse Clr, then pulse Clr again 3 cycles later:
  - Busy stays high for DEPTH+1 cycles after the second Clr, with a single ClrDone.
  - All entries read 0 afterwards.
  - A WrEn during the sweep gives WrDrop=1 and leaves the entry at 0.
- Assert Reset_n low mid-sweep and mid-read -> all outputs 0 immediately and FSM in IDLE. Repeat the write/read checks with ADDR_W=4, TGT_W=12, IMM_W=9, including entry 15.
